// File: rtl/class_vec_sequencer.sv
// Sweeps the class hypervector generator over every (class, frame) address
// and streams each chunk with its tags over a valid/ready output handshake.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, order_sel     launch a sweep (IDLE only); 0 class-major, 1 frame-major
//   abort                synchronous cancel, wins over start and load
//   gen_frame_id/index   address to the generator (0 while IDLE)
//   gen_vec              combinational generator word for that address
//   out_vec/class/frame  registered chunk and its tags
//   out_group_last       last beat of the inner loop
//   out_last             final beat of the sweep
//   out_valid/out_ready  output handshake
//   busy, done           RUN/DRAIN indicator, one-cycle completion pulse
module class_vec_sequencer #(
  parameter int DI_PARALLEL_W_BITS = 64,
  parameter int N_CLASSES          = 8,
  parameter int N_FRAMES           = 3,
  parameter int CLASS_W            = 3,
  parameter int FRAME_W            = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          order_sel,
  input  logic                          abort,
  output logic [CLASS_W-1:0]            gen_frame_id,
  output logic [FRAME_W-1:0]            gen_frame_index,
  input  logic [DI_PARALLEL_W_BITS-1:0] gen_vec,
  output logic [DI_PARALLEL_W_BITS-1:0] out_vec,
  output logic [CLASS_W-1:0]            out_class,
  output logic [FRAME_W-1:0]            out_frame,
  output logic                          out_group_last,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          done
);

  localparam logic [CLASS_W-1:0] CLS_MAX = CLASS_W'(N_CLASSES - 1);
  localparam logic [FRAME_W-1:0] FRM_MAX = FRAME_W'(N_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                          state, state_nx;
  logic                            order_q, order_nx;
  logic [CLASS_W-1:0]              cls_q, cls_nx;
  logic [FRAME_W-1:0]              frm_q, frm_nx;
  logic [DI_PARALLEL_W_BITS-1:0]   vec_nx;
  logic [CLASS_W-1:0]              tcls_nx;
  logic [FRAME_W-1:0]              tfrm_nx;
  logic                            gl_nx, last_nx, valid_nx, done_nx;
  logic                            load, hs, cls_end, frm_end;

  assign load    = (state == RUN) && (!out_valid || out_ready);
  assign hs      = out_valid && out_ready;
  assign cls_end = (cls_q == CLS_MAX);
  assign frm_end = (frm_q == FRM_MAX);

  assign gen_frame_id    = cls_q;
  assign gen_frame_index = frm_q;
  assign busy            = (state != IDLE);

  always_comb begin
    state_nx = state;
    order_nx = order_q;
    cls_nx   = cls_q;
    frm_nx   = frm_q;
    vec_nx   = out_vec;
    tcls_nx  = out_class;
    tfrm_nx  = out_frame;
    gl_nx    = out_group_last;
    last_nx  = out_last;
    valid_nx = out_valid;
    done_nx  = 1'b0;
    if (abort) begin
      state_nx = IDLE;
      valid_nx = 1'b0;
      cls_nx   = '0;
      frm_nx   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_nx = RUN;
            order_nx = order_sel;
            cls_nx   = '0;
            frm_nx   = '0;
          end
        end
        RUN: begin
          if (load) begin
            vec_nx   = gen_vec;
            tcls_nx  = cls_q;
            tfrm_nx  = frm_q;
            valid_nx = 1'b1;
            gl_nx    = order_q ? cls_end : frm_end;
            last_nx  = cls_end && frm_end;
            // Counters park on the final address until DRAIN completes.
            if (cls_end && frm_end) begin
              state_nx = DRAIN;
            end else if (!order_q) begin
              if (frm_end) begin
                frm_nx = '0;
                cls_nx = cls_q + CLASS_W'(1);
              end else begin
                frm_nx = frm_q + FRAME_W'(1);
              end
            end else begin
              if (cls_end) begin
                cls_nx = '0;
                frm_nx = frm_q + FRAME_W'(1);
              end else begin
                cls_nx = cls_q + CLASS_W'(1);
              end
            end
          end
        end
        DRAIN: begin
          if (hs) begin
            state_nx = IDLE;
            valid_nx = 1'b0;
            done_nx  = 1'b1;
            cls_nx   = '0;
            frm_nx   = '0;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      order_q        <= 1'b0;
      cls_q          <= '0;
      frm_q          <= '0;
      out_vec        <= '0;
      out_class      <= '0;
      out_frame      <= '0;
      out_group_last <= 1'b0;
      out_last       <= 1'b0;
      out_valid      <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_nx;
      order_q        <= order_nx;
      cls_q          <= cls_nx;
      frm_q          <= frm_nx;
      out_vec        <= vec_nx;
      out_class      <= tcls_nx;
      out_frame      <= tfrm_nx;
      out_group_last <= gl_nx;
      out_last       <= last_nx;
      out_valid      <= valid_nx;
      done           <= done_nx;
    end
  end

endmodule
